// File: rtl/playlist_controller.sv
// Purpose : playback controller - STOPPED/PLAYING/PAUSED FSM, per-song position timer,
//           auto-advance with normal / repeat-all / repeat-one / shuffle song selection.
// Latency : one clk edge from a sampled button rising edge to updated outputs; all outputs registered.
// Backpressure: none; each button edge is a single-cycle event, lower-priority edges in the same cycle are dropped.
// Ports   : clk, rst_n (async, active low); play_pause/stop/next/prev buttons (rising edge acts);
//           mode (00 normal, 01 repeat-all, 10 repeat-one, 11 shuffle);
//           is_playing, state, song, position, song_done pulse, end_of_list pulse.
module playlist_controller #(
    parameter int NUM_SONGS   = 8,
    parameter int SONG_W      = $clog2(NUM_SONGS),
    parameter int TRACK_LEN   = 16,
    parameter int POS_W       = $clog2(TRACK_LEN),
    parameter int TICK_DIV    = 4,
    parameter int RESTART_THR = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              play_pause,
    input  logic              stop,
    input  logic              next,
    input  logic              prev,
    input  logic [1:0]        mode,
    output logic              is_playing,
    output logic [1:0]        state,
    output logic [SONG_W-1:0] song,
    output logic [POS_W-1:0]  position,
    output logic              song_done,
    output logic              end_of_list
);

    // A one-cycle divider still needs a 1-bit counter to keep the code uniform.
    localparam int TICK_W = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_DIV - 1);
    localparam logic [POS_W-1:0]  POS_LAST  = POS_W'(TRACK_LEN - 1);
    localparam logic [SONG_W-1:0] SONG_LAST = SONG_W'(NUM_SONGS - 1);

    localparam logic [1:0] MODE_NORMAL     = 2'b00;
    localparam logic [1:0] MODE_REPEAT_ALL = 2'b01;
    localparam logic [1:0] MODE_REPEAT_ONE = 2'b10;
    localparam logic [1:0] MODE_SHUFFLE    = 2'b11;

    typedef enum logic [1:0] {
        ST_STOPPED = 2'b00,
        ST_PLAYING = 2'b01,
        ST_PAUSED  = 2'b10
    } state_t;

    state_t              r_state;
    logic                r_is_playing;
    logic [SONG_W-1:0]   r_song;
    logic [POS_W-1:0]    r_pos;
    logic [TICK_W-1:0]   r_tick;
    logic                r_done;
    logic                r_eol;
    logic [7:0]          r_lfsr;
    logic                r_pp_q;
    logic                r_stop_q;
    logic                r_next_q;
    logic                r_prev_q;

    logic                w_pp_press;
    logic                w_stop_press;
    logic                w_next_press;
    logic                w_prev_press;
    logic                w_next_act;
    logic                w_prev_act;
    logic                w_lfsr_fb;
    logic [SONG_W-1:0]   w_shuf_cand;
    logic [SONG_W-1:0]   w_shuf_song;
    logic [SONG_W-1:0]   w_manual_song;
    logic                w_restart;
    logic                w_tick_term;

    assign w_pp_press   = play_pause & ~r_pp_q;
    assign w_stop_press = stop       & ~r_stop_q;
    assign w_next_press = next       & ~r_next_q;
    assign w_prev_press = prev       & ~r_prev_q;

    // next and prev together cancel each other.
    assign w_next_act = w_next_press & ~w_prev_press;
    assign w_prev_act = w_prev_press & ~w_next_press;

    // x^8 + x^6 + x^5 + x^4 + 1
    assign w_lfsr_fb = r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3];

    // Shuffle never replays the current song back to back.
    assign w_shuf_cand = r_lfsr[SONG_W-1:0];
    assign w_shuf_song = (w_shuf_cand == r_song) ? w_shuf_cand + SONG_W'(1) : w_shuf_cand;

    // Manual next always wraps (NUM_SONGS is a power of two, so +1 wraps for free).
    assign w_manual_song = (mode == MODE_SHUFFLE) ? w_shuf_song : r_song + SONG_W'(1);

    assign w_restart   = (int'(r_pos) >= RESTART_THR);
    assign w_tick_term = (r_tick == TICK_LAST);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_STOPPED;
            r_is_playing <= 1'b0;
            r_song       <= '0;
            r_pos        <= '0;
            r_tick       <= '0;
            r_done       <= 1'b0;
            r_eol        <= 1'b0;
            r_lfsr       <= 8'hA5;
            // Buttons held through reset release must not count as presses.
            r_pp_q       <= 1'b1;
            r_stop_q     <= 1'b1;
            r_next_q     <= 1'b1;
            r_prev_q     <= 1'b1;
        end else begin
            r_pp_q   <= play_pause;
            r_stop_q <= stop;
            r_next_q <= next;
            r_prev_q <= prev;
            r_lfsr   <= {r_lfsr[6:0], w_lfsr_fb};
            r_done   <= 1'b0;
            r_eol    <= 1'b0;

            // Button actions take precedence over end-of-song, which suppresses its pulses.
            if (w_stop_press) begin
                r_state      <= ST_STOPPED;
                r_is_playing <= 1'b0;
                r_pos        <= '0;
                r_tick       <= '0;
            end else if (w_pp_press) begin
                case (r_state)
                    ST_PLAYING: begin
                        r_state      <= ST_PAUSED;
                        r_is_playing <= 1'b0;
                    end
                    ST_PAUSED: begin
                        r_state      <= ST_PLAYING;
                        r_is_playing <= 1'b1;
                    end
                    default: begin
                        r_state      <= ST_PLAYING;
                        r_is_playing <= 1'b1;
                        r_pos        <= '0;
                        r_tick       <= '0;
                    end
                endcase
            end else if (w_next_act) begin
                r_song <= w_manual_song;
                r_pos  <= '0;
                r_tick <= '0;
            end else if (w_prev_act) begin
                // Far enough into the song, prev restarts it instead of stepping back.
                if (!w_restart) begin
                    r_song <= r_song - SONG_W'(1);
                end
                r_pos  <= '0;
                r_tick <= '0;
            end else if (r_state == ST_PLAYING) begin
                if (!w_tick_term) begin
                    r_tick <= r_tick + TICK_W'(1);
                end else begin
                    r_tick <= '0;
                    if (r_pos != POS_LAST) begin
                        r_pos <= r_pos + POS_W'(1);
                    end else begin
                        r_done <= 1'b1;
                        r_pos  <= '0;
                        case (mode)
                            MODE_NORMAL: begin
                                if (r_song == SONG_LAST) begin
                                    r_state      <= ST_STOPPED;
                                    r_is_playing <= 1'b0;
                                    r_eol        <= 1'b1;
                                end else begin
                                    r_song <= r_song + SONG_W'(1);
                                end
                            end
                            MODE_REPEAT_ALL: r_song <= r_song + SONG_W'(1);
                            MODE_REPEAT_ONE: r_song <= r_song;
                            default:         r_song <= w_shuf_song;
                        endcase
                    end
                end
            end
        end
    end

    assign is_playing  = r_is_playing;
    assign state       = r_state;
    assign song        = r_song;
    assign position    = r_pos;
    assign song_done   = r_done;
    assign end_of_list = r_eol;

endmodule

// File: tb/tb_playlist_controller.sv
// Purpose : scoreboard bench for playlist_controller with 4 songs, 4 ticks per song, 2 clocks per tick.
// Latency : expectations are pushed when inputs are driven and compared just after the following edge.
// Backpressure: none; a separate monitor matches every song_done/end_of_list pulse against a pulse queue.
module tb_playlist_controller;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       play_pause = 1'b0;
    logic       stop = 1'b0;
    logic       next = 1'b0;
    logic       prev = 1'b0;
    logic [1:0] mode = 2'b00;
    logic       is_playing;
    logic [1:0] state;
    logic [1:0] song;
    logic [1:0] position;
    logic       song_done;
    logic       end_of_list;

    always #5 clk = ~clk;

    playlist_controller #(
        .NUM_SONGS  (4),
        .TRACK_LEN  (4),
        .TICK_DIV   (2),
        .RESTART_THR(2)
    ) u_dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .play_pause (play_pause),
        .stop       (stop),
        .next       (next),
        .prev       (prev),
        .mode       (mode),
        .is_playing (is_playing),
        .state      (state),
        .song       (song),
        .position   (position),
        .song_done  (song_done),
        .end_of_list(end_of_list)
    );

    int n_checks = 0;
    int n_errors = 0;

    // {is_playing, state, song_done, end_of_list, song, position}
    logic [8:0] exp_q[$];
    string      name_q[$];
    // {end_of_list, song}
    logic [2:0] pulse_q[$];

    logic [7:0] m_lfsr;

    // Reference shuffle source: 8-bit Fibonacci LFSR, seed A5, taps 8,6,5,4.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) m_lfsr <= 8'hA5;
        else        m_lfsr <= {m_lfsr[6:0], m_lfsr[7] ^ m_lfsr[5] ^ m_lfsr[4] ^ m_lfsr[3]};
    end

    function automatic logic [8:0] mk_exp(input logic [1:0] st, input logic [1:0] sg,
                                          input logic [1:0] ps, input logic dn, input logic el);
        return {st == 2'b01, st, dn, el, sg, ps};
    endfunction

    task automatic expect_out(input string nm, input logic [1:0] st, input logic [1:0] sg,
                              input logic [1:0] ps, input logic dn = 1'b0, input logic el = 1'b0);
        exp_q.push_back(mk_exp(st, sg, ps, dn, el));
        name_q.push_back(nm);
        if (dn) pulse_q.push_back({el, sg});
    endtask

    task automatic drive(input logic pp, input logic st, input logic nx, input logic pv,
                         input logic [1:0] md);
        @(negedge clk);
        play_pause = pp;
        stop       = st;
        next       = nx;
        prev       = pv;
        mode       = md;
    endtask

    // Eight idle PLAYING edges from position 0 / tick 0 ending at the song boundary.
    task automatic play_song(input string nm, input logic [1:0] md, input logic [1:0] s,
                             input logic [1:0] nxt_song, input logic [1:0] end_st, input logic eol);
        for (int k = 1; k <= 8; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, md);
            if (k < 8) expect_out(nm, 2'b01, s, 2'(k / 2));
            else       expect_out({nm, "_end"}, end_st, nxt_song, 2'd0, 1'b1, eol);
        end
    endtask

    task automatic run_edges(input string nm, input logic [1:0] md, input logic [1:0] s, input int n);
        for (int k = 1; k <= n; k++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, md);
            expect_out(nm, 2'b01, s, 2'(k / 2));
        end
    endtask

    // Output monitor: compares one queued expectation after each edge (clock or async reset).
    initial begin : mon
        logic [8:0] e;
        logic [8:0] got;
        string      nm;
        forever begin
            @(posedge clk or negedge rst_n);
            #1;
            if (exp_q.size() > 0) begin
                e   = exp_q.pop_front();
                nm  = name_q.pop_front();
                got = {is_playing, state, song_done, end_of_list, song, position};
                n_checks++;
                if (got !== e) begin
                    n_errors++;
                    $display("FAIL %s: got play=%0b state=%0d done=%0b eol=%0b song=%0d pos=%0d, want play=%0b state=%0d done=%0b eol=%0b song=%0d pos=%0d",
                             nm, got[8], got[7:6], got[5], got[4], got[3:2], got[1:0],
                             e[8], e[7:6], e[5], e[4], e[3:2], e[1:0]);
                end
            end
        end
    end

    // Pulse monitor: every song_done/end_of_list the DUT raises must be an expected one.
    initial begin : pmon
        logic [2:0] p;
        forever begin
            @(posedge clk);
            #1;
            if (song_done || end_of_list) begin
                n_checks++;
                if (pulse_q.size() == 0) begin
                    n_errors++;
                    $display("FAIL unexpected_pulse: got done=%0b eol=%0b song=%0d, want no pulse",
                             song_done, end_of_list, song);
                end else begin
                    p = pulse_q.pop_front();
                    if (!song_done || end_of_list !== p[2] || song !== p[1:0]) begin
                        n_errors++;
                        $display("FAIL pulse: got done=%0b eol=%0b song=%0d, want done=1 eol=%0b song=%0d",
                                 song_done, end_of_list, song, p[2], p[1:0]);
                    end
                end
            end
        end
    end

    initial begin : watchdog
        #100000;
        $display("FAIL watchdog: got simulation still running at 100000, want finished");
        $fatal(1, "timeout");
    end

    initial begin : stim
        logic [1:0] cur_song;
        logic [1:0] cand;
        logic [1:0] exp_s;

        rst_n      = 1'b0;
        play_pause = 1'b1;
        repeat (3) @(negedge clk);

        // play_pause held through reset release is not a press
        rst_n = 1'b1;
        expect_out("hold_through_reset", 2'b00, 2'd0, 2'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        expect_out("still_stopped", 2'b00, 2'd0, 2'd0);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        expect_out("play_press", 2'b01, 2'd0, 2'd0);

        // normal mode through the whole list
        play_song("normal_s0", 2'b00, 2'd0, 2'd1, 2'b01, 1'b0);
        play_song("normal_s1", 2'b00, 2'd1, 2'd2, 2'b01, 1'b0);
        play_song("normal_s2", 2'b00, 2'd2, 2'd3, 2'b01, 1'b0);
        play_song("normal_s3", 2'b00, 2'd3, 2'd3, 2'b00, 1'b1);

        // repeat-all wraps the last song to 0
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b01);
        expect_out("replay_s3", 2'b01, 2'd3, 2'd0);
        play_song("rptall_s3", 2'b01, 2'd3, 2'd0, 2'b01, 1'b0);

        // prev at position 0 of song 0 wraps to song 3
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b10);
        expect_out("prev_wrap", 2'b01, 2'd3, 2'd0);
        play_song("rptone_s3", 2'b10, 2'd3, 2'd3, 2'b01, 1'b0);

        // prev at position 3 on the end-of-song edge: restart wins, no song_done
        run_edges("to_pos3", 2'b01, 2'd3, 7);
        drive(1'b0, 1'b0, 1'b0, 1'b1, 2'b01);
        expect_out("prev_restart_at_end", 2'b01, 2'd3, 2'd0);

        // stop on the end of the last song in normal mode: no song_done, no end_of_list
        run_edges("to_end_s3", 2'b00, 2'd3, 7);
        drive(1'b0, 1'b1, 1'b0, 1'b0, 2'b00);
        expect_out("stop_at_end", 2'b00, 2'd3, 2'd0);

        // next + prev together are ignored, the timer keeps running
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        expect_out("play_again", 2'b01, 2'd3, 2'd0);
        drive(1'b0, 1'b0, 1'b1, 1'b1, 2'b00);
        expect_out("next_prev_both", 2'b01, 2'd3, 2'd0);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        expect_out("after_both", 2'b01, 2'd3, 2'd1);

        // stop beats play_pause
        drive(1'b1, 1'b1, 1'b0, 1'b0, 2'b00);
        expect_out("stop_and_pp", 2'b00, 2'd3, 2'd0);

        // shuffle: 20 manual next presses while stopped
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
        cur_song = 2'd3;
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b11);
            cand  = m_lfsr[1:0];
            exp_s = (cand == cur_song) ? cand + 2'd1 : cand;
            expect_out("shuffle_next", 2'b00, exp_s, 2'd0);
            cur_song = exp_s;
            drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b11);
        end

        // pause at position 2 holds, resume advances after one tick period
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        expect_out("play_shuf_song", 2'b01, cur_song, 2'd0);
        run_edges("pre_pause", 2'b00, cur_song, 4);
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        expect_out("pause", 2'b10, cur_song, 2'd2);
        for (int i = 0; i < 10; i++) begin
            drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
            expect_out("paused_hold", 2'b10, cur_song, 2'd2);
        end
        drive(1'b1, 1'b0, 1'b0, 1'b0, 2'b00);
        expect_out("resume", 2'b01, cur_song, 2'd2);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        expect_out("resume_t1", 2'b01, cur_song, 2'd2);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        expect_out("resume_t2", 2'b01, cur_song, 2'd3);

        // asynchronous reset between clock edges
        @(negedge clk);
        #2;
        expect_out("async_reset", 2'b00, 2'd0, 2'd0);
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;

        // LFSR restarts at A5: one shift later it is 4A, so shuffle picks song 2
        drive(1'b0, 1'b0, 1'b1, 1'b0, 2'b11);
        expect_out("shuffle_after_reset", 2'b00, 2'd2, 2'd0);

        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        drive(1'b0, 1'b0, 1'b0, 1'b0, 2'b00);
        @(posedge clk);
        #2;

        n_checks++;
        if (exp_q.size() != 0) begin
            n_errors++;
            $display("FAIL drain_expect: got %0d pending, want 0", exp_q.size());
        end
        n_checks++;
        if (pulse_q.size() != 0) begin
            n_errors++;
            $display("FAIL missing_pulse: got %0d pulses not seen, want 0", pulse_q.size());
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/playlist_controller.md
# playlist_controller

Parametrised playback controller for the music-player subsystem. Generalises the fixed 4-song toggle player to a configurable song count with:
- edge-detected buttons
- an explicit STOPPED/PLAYING/PAUSED state machine
- a per-song position timer with auto-advance
- selectable normal, repeat-all, repeat-one and shuffle modes

It sits between the debounced front-panel buttons and the audio fetch/display logic.

## Interface
- NUM_SONGS, 8, number of songs; power of two, 2..256
- SONG_W, $clog2(NUM_SONGS), width of song index
- TRACK_LEN, 16, position ticks per song (≥2)
- POS_W, $clog2(TRACK_LEN), width of position
- TICK_DIV, 4, clk cycles per position tick (≥1)
- RESTART_THR, 2, prev restarts current song when position ≥ this

Ports:
- clk  in  1  system clock, rising edge
- rst_n  in  1  asynchronous, active-low reset
- play_pause  in  1  toggle play/pause (level; rising edge acts)
- stop  in  1  stop playback (rising edge acts)
- next  in  1  next song (rising edge acts)
- prev  in  1  previous song / restart (rising edge acts)
- mode  in  2  00 normal, 01 repeat-all, 10 repeat-one, 11 shuffle
- is_playing  out  1  high in PLAYING
- state  out  2  00 STOPPED, 01 PLAYING, 10 PAUSED
- song  out  SONG_W  current song index
- position  out  POS_W  tick position within current song
- song_done  out  1  one-cycle pulse when a song reaches its end
- end_of_list  out  1  one-cycle pulse when normal mode finishes the last song

## Operation
- All inputs are synchronous to clk.
- Each button has a registered previous value; press = input high AND previous low.
- Previous-value registers reset to 1, so a button held through reset release is not a press.
- Priority per cycle: stop > play_pause > next/prev. A lower-priority press in the same cycle is dropped. next and prev pressed together are both ignored.
- State transitions:
  - STOPPED: play_pause → PLAYING (song kept, position 0)
  - PLAYING: play_pause → PAUSED; stop → STOPPED
  - PAUSED: play_pause → PLAYING; stop → STOPPED
  - stop from any state: position and tick counter clear to 0, song kept
- Tick counter counts 0..TICK_DIV-1 only in PLAYING; holds in PAUSED; clears in STOPPED and on any song change.
- position increments when the tick counter is at TICK_DIV-1.
- End of song: position == TRACK_LEN-1 and tick terminal. song_done pulses; action by mode:
  - normal: song+1 if not last. If last, song unchanged, state → STOPPED, position 0, end_of_list pulses.
  - repeat-all: song+1, wrapping NUM_SONGS-1 → 0
  - repeat-one: song unchanged, position 0
  - shuffle: candidate = LFSR[SONG_W-1:0]; if candidate == song, use candidate+1 (wrapping)
- Manual next, any state: same song selection as auto-advance, except normal and repeat-one wrap last → 0. Never stops playback. position 0.
- Manual prev, any state:
  - position ≥ RESTART_THR: position 0, song kept
  - otherwise: song-1, wrapping 0 → NUM_SONGS-1, position 0
- LFSR:
  - 8-bit Fibonacci, taps x^8+x^6+x^5+x^4+1, seed 8'hA5
  - shifts every cycle regardless of state
- mode is sampled at the moment of use; changing mode mid-song has no other effect.

## Timing
- Reset values:
  - state STOPPED, is_playing 0, song 0, position 0
  - song_done 0, end_of_list 0, tick counter 0, LFSR 8'hA5
- Press latency: outputs reflect a press after the first rising clk edge at which the input is sampled high with previous sample low. A press produces exactly one action however long the input is held.
- position advances once every TICK_DIV cycles while PLAYING.
- Song change on end-of-song takes effect at the same edge as song_done. song_done and end_of_list are high for exactly that one cycle.
- A manual press coinciding with end-of-song wins: the button action is applied and song_done is suppressed. stop in that cycle also suppresses end_of_list.
- rst_n low mid-playback forces reset values immediately (asynchronous). Operation resumes on the first clk edge after release.

## Test plan
- Setup for all scenarios: NUM_SONGS=4, TRACK_LEN=4, TICK_DIV=2.
- Reset, hold play_pause high through rst_n release → state stays STOPPED; then release and press play_pause → state=01, is_playing=1, song=0, position=0.
- PLAYING in normal mode for 8 cycles → position steps 0,1,2,3 every 2 cycles; song_done pulse; song=1, position=0. Continue to song 3 end → end_of_list pulse, state=00, song=3.
- Repeat-all at song 3 end → song=0, still PLAYING. Repeat-one → song stays 3, position wraps to 0.
- prev at position 3 → position 0, song kept. prev at position 0, song 0 → song=3. next+prev together → no change. stop+play_pause together → STOPPED.
- Shuffle, 20 consecutive next presses → song never equals the previous song, always <4. Sequence matches a model LFSR seeded 8'hA5.
- PAUSE at position 2 for 10 cycles → position holds 2. Resume → advances after 2 cycles. Assert rst_n low mid-song → all outputs reset values asynchronously.
